// File: rtl/m_multicycle_ctrl_pkg.sv
// Shared encodings and field helpers for the RV32 add/logic multi-cycle controller.
package m_multicycle_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned ST_W  = 3;
    localparam int unsigned ALU_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    localparam logic [OPC_W-1:0] OP_R      = 7'h33;
    localparam logic [OPC_W-1:0] OP_SYSTEM = 7'h73;

    localparam logic [F3_W-1:0] F3_ADD_SUB = 3'd0;
    localparam logic [F3_W-1:0] F3_AND     = 3'd7;
    localparam logic [F3_W-1:0] F3_OR      = 3'd6;
    localparam logic [F3_W-1:0] F3_PRIV    = 3'd0;

    localparam logic [F7_W-1:0] F7_BASE = 7'h00;
    localparam logic [F7_W-1:0] F7_ALT  = 7'h20;

    // Fields captured from the instruction word at FETCH.
    typedef struct packed {
        logic [F7_W-1:0]  funct7;
        logic [REG_W-1:0] rd;
        logic [F3_W-1:0]  funct3;
        logic [OPC_W-1:0] opcode;
        logic             regs_zero;
    } ir_fields_t;

    // Split an instruction word; regs_zero flags rd, rs1 and rs2 all zero (needed for exact ECALL).
    function automatic ir_fields_t split_ir(input logic [XLEN-1:0] ir);
        ir_fields_t f;
        f.funct7    = ir[31:25];
        f.rd        = ir[11:7];
        f.funct3    = ir[14:12];
        f.opcode    = ir[6:0];
        f.regs_zero = (ir[24:15] == 10'd0) && (ir[11:7] == 5'd0);
        return f;
    endfunction

endpackage

// File: rtl/m_rv_decode.sv
// Combinational classifier for the supported R-type add/logic ops and ECALL.
module m_rv_decode
    import m_multicycle_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct3,
    input  logic [F7_W-1:0]  funct7,
    output logic             valid,
    output logic             ecall,
    output alu_op_e          alu_op
);

    // Map opcode/funct3/funct7 to an ALU op, or flag a SYSTEM/PRIV encoding.
    always_comb begin
        valid  = 1'b0;
        ecall  = 1'b0;
        alu_op = ALU_ADD;
        if (opcode == OP_R) begin
            if (funct7 == F7_BASE && funct3 == F3_ADD_SUB) begin
                valid  = 1'b1;
                alu_op = ALU_ADD;
            end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                valid  = 1'b1;
                alu_op = ALU_SUB;
            end else if (funct7 == F7_BASE && funct3 == F3_AND) begin
                valid  = 1'b1;
                alu_op = ALU_AND;
            end else if (funct7 == F7_BASE && funct3 == F3_OR) begin
                valid  = 1'b1;
                alu_op = ALU_OR;
            end
        end else if (opcode == OP_SYSTEM && funct3 == F3_PRIV && funct7 == F7_BASE) begin
            ecall = 1'b1;
        end
    end

endmodule

// File: rtl/m_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the RV32 add/logic datapath.
module m_multicycle_ctrl
    import m_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              w_clock,
    input  logic              w_rst_n,
    input  logic              w_run,
    input  logic              w_imem_ready,
    input  logic [XLEN-1:0]   w_ir,
    output logic              w_ir_en,
    output logic              w_pc_en,
    output logic              w_rf_we,
    output logic [ALU_W-1:0]  w_alu_op,
    output logic [ST_W-1:0]   w_state,
    output logic              w_illegal,
    output logic              w_halted,
    output logic [CNT_W-1:0]  w_retired
);

    state_e     state_q,   state_d;
    ir_fields_t fields_q,  fields_d;
    alu_op_e    alu_op_q,  alu_op_d;
    logic       illegal_q, illegal_d;
    logic       halted_q,  halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic    dec_valid;
    logic    dec_ecall;
    alu_op_e dec_alu_op;

    m_rv_decode u_decode (
        .opcode (fields_q.opcode),
        .funct3 (fields_q.funct3),
        .funct7 (fields_q.funct7),
        .valid  (dec_valid),
        .ecall  (dec_ecall),
        .alu_op (dec_alu_op)
    );

    // Next-state and next-register values for the sequencer.
    always_comb begin
        state_d   = state_q;
        fields_d  = fields_q;
        alu_op_d  = alu_op_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (w_run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_imem_ready) begin
                    fields_d = split_ir(w_ir);
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_valid) begin
                    alu_op_d = dec_alu_op;
                    state_d  = ST_EXEC;
                end else if (dec_ecall && fields_q.regs_zero) begin
                    state_d = ST_HALT;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = w_run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        halted_d = (state_d == ST_HALT);
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge w_clock) begin
        if (!w_rst_n) begin
            state_q   <= ST_IDLE;
            fields_q  <= '0;
            alu_op_q  <= ALU_ADD;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            fields_q  <= fields_d;
            alu_op_q  <= alu_op_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    // Single-cycle strobes decoded from the current state.
    assign w_ir_en = (state_q == ST_FETCH) && w_imem_ready;
    assign w_pc_en = (state_q == ST_WB);
    assign w_rf_we = (state_q == ST_WB) && (fields_q.rd != 5'd0);

    assign w_alu_op  = alu_op_q;
    assign w_state   = state_q;
    assign w_illegal = illegal_q;
    assign w_halted  = halted_q;
    assign w_retired = retired_q;

endmodule

// File: tb/tb_m_multicycle_ctrl.sv
// Randomized self-checking bench for m_multicycle_ctrl against a transaction-level model.
module tb_m_multicycle_ctrl;

    localparam int unsigned TB_CNT_W = 4;
    localparam int unsigned CNT_MOD  = 16;

    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_ECALL = 4, K_ILL = 5;

    logic                w_clock;
    logic                w_rst_n;
    logic                w_run;
    logic                w_imem_ready;
    logic [31:0]         w_ir;
    logic                w_ir_en;
    logic                w_pc_en;
    logic                w_rf_we;
    logic [1:0]          w_alu_op;
    logic [2:0]          w_state;
    logic                w_illegal;
    logic                w_halted;
    logic [TB_CNT_W-1:0] w_retired;

    int errors;
    int checks;

    // Model: what the architecture should show, tracked per instruction.
    int m_retired;
    int m_alu;
    bit m_illegal;
    bit m_halted;
    bit m_idle;

    m_multicycle_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .w_clock      (w_clock),
        .w_rst_n      (w_rst_n),
        .w_run        (w_run),
        .w_imem_ready (w_imem_ready),
        .w_ir         (w_ir),
        .w_ir_en      (w_ir_en),
        .w_pc_en      (w_pc_en),
        .w_rf_we      (w_rf_we),
        .w_alu_op     (w_alu_op),
        .w_state      (w_state),
        .w_illegal    (w_illegal),
        .w_halted     (w_halted),
        .w_retired    (w_retired)
    );

    initial w_clock = 1'b0;
    always #5 w_clock = ~w_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge w_clock);
        #1;
    endtask

    // Instruction class from the ISA encoding rules, using whole-word masks.
    function automatic int classify(input logic [31:0] w);
        logic [31:0] m;
        m = w & 32'hFE00707F;
        if (m == 32'h00000033) return K_ADD;
        if (m == 32'h40000033) return K_SUB;
        if (m == 32'h00007033) return K_AND;
        if (m == 32'h00006033) return K_OR;
        if (w == 32'h00000073) return K_ECALL;
        return K_ILL;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] base;
        logic [31:0] w;
        int pick;
        int bitpos;
        int sel;
        sel = $urandom_range(0, 3);
        case (sel)
            0: base = 32'h00000033;
            1: base = 32'h40000033;
            2: base = 32'h00007033;
            default: base = 32'h00006033;
        endcase
        w = base | ({27'd0, 5'($urandom)} << 7) | ({27'd0, 5'($urandom)} << 15) | ({27'd0, 5'($urandom)} << 20);
        if ($urandom_range(0, 9) == 0) w = w & ~32'h00000F80;
        pick = $urandom_range(0, 9);
        if (pick == 7) begin
            w = 32'h00000073;
        end else if (pick == 8) begin
            bitpos = $urandom_range(0, 16);
            if (bitpos > 6) bitpos = bitpos + 5;
            if (bitpos > 14) bitpos = bitpos + 10;
            w = w ^ (32'd1 << bitpos);
        end else if (pick == 9) begin
            w = $urandom;
        end
        return w;
    endfunction

    // Apply synchronous reset for one edge and check every output.
    task automatic reset_check(input string tag);
        w_rst_n      = 1'b0;
        w_run        = 1'($urandom);
        w_imem_ready = 1'($urandom);
        w_ir         = $urandom;
        tick();
        chk({tag, "_state"},   32'(w_state), 32'd0);
        chk({tag, "_strobes"}, 32'({w_ir_en, w_pc_en, w_rf_we}), 32'd0);
        chk({tag, "_alu_op"},  32'(w_alu_op), 32'd0);
        chk({tag, "_illegal"}, 32'(w_illegal), 32'd0);
        chk({tag, "_halted"},  32'(w_halted), 32'd0);
        chk({tag, "_retired"}, 32'(w_retired), 32'd0);
        w_rst_n   = 1'b1;
        w_run     = 1'b0;
        m_retired = 0;
        m_alu     = 0;
        m_illegal = 1'b0;
        m_halted  = 1'b0;
        m_idle    = 1'b1;
    endtask

    // In IDLE: optionally dwell with run low, then raise run to reach FETCH.
    task automatic start(input int dwell);
        for (int i = 0; i < dwell; i++) begin
            w_run        = 1'b0;
            w_imem_ready = 1'($urandom);
            #1;
            chk("idle_dwell_state",   32'(w_state), 32'd0);
            chk("idle_dwell_strobes", 32'({w_ir_en, w_pc_en, w_rf_we}), 32'd0);
            tick();
        end
        w_run        = 1'b1;
        w_imem_ready = 1'($urandom);
        #1;
        chk("idle_state",   32'(w_state), 32'd0);
        chk("idle_strobes", 32'({w_ir_en, w_pc_en, w_rf_we}), 32'd0);
        tick();
        m_idle = 1'b0;
    endtask

    // Hold in HALT with run and ready high: nothing may move.
    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            w_run        = 1'b1;
            w_imem_ready = 1'b1;
            w_ir         = rand_word();
            #1;
            chk("halt_hold_state",   32'(w_state), 32'd5);
            chk("halt_hold_halted",  32'(w_halted), 32'd1);
            chk("halt_hold_strobes", 32'({w_ir_en, w_pc_en, w_rf_we}), 32'd0);
            chk("halt_hold_retired", 32'(w_retired), 32'(m_retired));
        end
    endtask

    // One instruction from FETCH; run_after is what w_run holds from EXEC through WB.
    task automatic run_instr(input logic [31:0] word, input int stalls, input logic run_after,
                             input bit abort_exec);
        int kind;
        kind = classify(word);
        for (int i = 0; i < stalls; i++) begin
            w_imem_ready = 1'b0;
            w_ir         = $urandom;
            w_run        = 1'($urandom);
            #1;
            chk("stall_state",   32'(w_state), 32'd1);
            chk("stall_strobes", 32'({w_ir_en, w_pc_en, w_rf_we}), 32'd0);
            tick();
        end
        w_imem_ready = 1'b1;
        w_ir         = word;
        w_run        = 1'($urandom);
        #1;
        chk("fetch_state",   32'(w_state), 32'd1);
        chk("fetch_strobes", 32'({w_ir_en, w_pc_en, w_rf_we}), 32'b100);
        tick();
        w_imem_ready = 1'($urandom);
        w_ir         = $urandom;
        w_run        = 1'($urandom);
        #1;
        chk("decode_state",   32'(w_state), 32'd2);
        chk("decode_strobes", 32'({w_ir_en, w_pc_en, w_rf_we}), 32'd0);
        tick();
        w_imem_ready = 1'($urandom);
        w_ir         = $urandom;
        #1;
        if (kind == K_ECALL || kind == K_ILL) begin
            if (kind == K_ILL) m_illegal = 1'b1;
            m_halted = 1'b1;
            chk("halt_state",   32'(w_state), 32'd5);
            chk("halt_halted",  32'(w_halted), 32'd1);
            chk("halt_illegal", 32'(w_illegal), 32'(m_illegal));
            chk("halt_retired", 32'(w_retired), 32'(m_retired));
            chk("halt_strobes", 32'({w_ir_en, w_pc_en, w_rf_we}), 32'd0);
            return;
        end
        m_alu = kind;
        chk("exec_state",   32'(w_state), 32'd3);
        chk("exec_alu_op",  32'(w_alu_op), 32'(m_alu));
        chk("exec_strobes", 32'({w_ir_en, w_pc_en, w_rf_we}), 32'd0);
        if (abort_exec) begin
            reset_check("abort_exec");
            return;
        end
        w_run = run_after;
        tick();
        w_imem_ready = 1'($urandom);
        w_ir         = $urandom;
        #1;
        chk("wb_state",   32'(w_state), 32'd4);
        chk("wb_pc_en",   32'(w_pc_en), 32'd1);
        chk("wb_rf_we",   32'(w_rf_we), 32'(word[11:7] != 5'd0));
        chk("wb_ir_en",   32'(w_ir_en), 32'd0);
        chk("wb_alu_op",  32'(w_alu_op), 32'(m_alu));
        chk("wb_illegal", 32'(w_illegal), 32'(m_illegal));
        tick();
        m_retired = (m_retired + 1) % CNT_MOD;
        m_idle    = !run_after;
        chk("retired",  32'(w_retired), 32'(m_retired));
        chk("after_wb", 32'(w_state), run_after ? 32'd1 : 32'd0);
        chk("after_wb_halted", 32'(w_halted), 32'd0);
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        w_rst_n      = 1'b0;
        w_run        = 1'b0;
        w_imem_ready = 1'b0;
        w_ir         = 32'd0;
        #1;
        reset_check("por");

        // Program: add, sub, and, or, then ecall.
        start(0);
        run_instr(32'h002082B3, 0, 1'b1, 1'b0);
        run_instr(32'h406283B3, 0, 1'b1, 1'b0);
        run_instr(32'h0020F333, 0, 1'b1, 1'b0);
        run_instr(32'h0020E333, 0, 1'b1, 1'b0);
        chk("prog_retired", 32'(w_retired), 32'd4);
        run_instr(32'h00000073, 0, 1'b1, 1'b0);
        chk("ecall_not_illegal", 32'(w_illegal), 32'd0);
        hold_halt(5);
        reset_check("rst_in_halt");

        // Unsupported addi halts as illegal.
        start(1);
        run_instr(32'h00000013, 0, 1'b1, 1'b0);
        hold_halt(3);
        reset_check("rst_after_illegal");

        // rd=x0 suppresses the write; stall then drop run in EXEC.
        start(0);
        run_instr(32'h00208033, 0, 1'b1, 1'b0);
        run_instr(32'h002082B3, 3, 1'b0, 1'b0);

        // Reset during EXEC aborts without a WB pulse, then restart.
        start(2);
        run_instr(32'h002082B3, 0, 1'b1, 1'b1);
        start(0);
        run_instr(32'h0020E333, 1, 1'b1, 1'b0);

        // Random instruction stream with stalls, run toggles and halts.
        for (int n = 0; n < 150; n++) begin
            if (m_halted) begin
                hold_halt($urandom_range(1, 2));
                reset_check("rand_rst");
            end
            if (m_idle) start($urandom_range(0, 2));
            run_instr(rand_word(), $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog keeps the run bounded even if the bench stalls on a clock edge.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/m_multicycle_ctrl.md
# m_multicycle_ctrl

Multi-cycle sequencer for the RV32 integer add/logic datapath (PC adder, register file, ALU adder).
- Steps each instruction through FETCH, DECODE, EXEC and WB, and drives PC load, IR latch, register-file write enable and ALU operation select.
- Detects unsupported encodings and halts on them or on ECALL.
- Counts retired instructions.
- Sits between instruction memory and the datapath, replacing the free-running "PC advances every clock, RF always writes" behaviour.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports (all registered unless noted):
- w_clock  in  1  rising-edge clock
- w_rst_n  in  1  reset; synchronous, active-low
- w_run  in  1  1 = fetch new instructions; 0 = finish current instruction, then idle
- w_imem_ready  in  1  instruction word on w_ir is valid this cycle
- w_ir  in  32  instruction word from instruction memory
- w_ir_en  out  1  combinational; latch w_ir into datapath IR this cycle
- w_pc_en  out  1  combinational; load r_pc <= npc this cycle
- w_rf_we  out  1  combinational; register-file write enable
- w_alu_op  out  2  ALU select: 0 ADD, 1 SUB, 2 AND, 3 OR; held from DECODE through WB
- w_state  out  3  current FSM state encoding (debug)
- w_illegal  out  1  sticky; illegal instruction seen
- w_halted  out  1  in HALT state
- w_retired  out  CNT_W  instructions completed through WB

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. Encodings 6–7 are unreachable and go to IDLE.
- IDLE: go to FETCH when w_run=1; otherwise stay.
- FETCH:
  - Wait while w_imem_ready=0.
  - When ready: w_ir_en=1 for exactly that cycle. The controller captures opcode[6:0], funct3, funct7 and rd internally, then moves to DECODE.
- DECODE: classify the captured fields.
  - opcode 0x33, funct7 0x00, funct3 0 → ADD.
  - opcode 0x33, funct7 0x20, funct3 0 → SUB.
  - opcode 0x33, funct7 0x00, funct3 7 → AND.
  - opcode 0x33, funct7 0x00, funct3 6 → OR.
  - Any of the above: set w_alu_op and go to EXEC.
  - Exactly 0x00000073 (ECALL): go to HALT, w_illegal unchanged.
  - Anything else: set w_illegal=1 and go to HALT.
- EXEC: one cycle for ALU/adder settle; go to WB.
- WB:
  - w_pc_en=1.
  - w_rf_we=1 unless captured rd==0, in which case it is suppressed.
  - w_retired increments by 1, wrapping modulo 2^CNT_W.
  - Next state: FETCH if w_run=1, else IDLE.
- HALT: terminal.
  - All enables 0; w_halted=1.
  - Only w_rst_n=0 exits.
  - PC is not advanced for the halting instruction.
- w_run dropping mid-instruction: no effect until WB. The instruction always completes.
- w_run in HALT: ignored.

## Timing
- Reset (w_rst_n=0 at a rising edge) gives on the next cycle:
  - state IDLE; w_ir_en, w_pc_en, w_rf_we = 0.
  - w_alu_op=0, w_illegal=0, w_halted=0, w_retired=0.
  - Reset mid-instruction aborts it with no WB pulse.
- Minimum instruction latency is 4 cycles (FETCH, DECODE, EXEC, WB) with w_imem_ready=1. Each FETCH stall cycle adds 1.
- Back-to-back throughput with w_run=1 and memory ready is 1 instruction per 4 cycles.
- w_ir_en, w_pc_en and w_rf_we are single-cycle pulses. They never overlap, and are never asserted in IDLE or HALT.
- Decode-to-HALT: the HALT state is visible the cycle after DECODE.
- w_halted and w_illegal rise together in that same cycle.

## Structure
- Shared defines/package holds:
  - state encodings;
  - ALU op codes;
  - opcode constants OP_R=0x33 and OP_SYSTEM=0x73;
  - funct3/funct7 constants.
- One sub-module, m_rv_decode: purely combinational.
  - Inputs: captured opcode/funct3/funct7.
  - Outputs: valid, ecall, alu_op.
  - Reusable by the pipelined core.
- Main FSM, capture registers and counter live in m_multicycle_ctrl.

## Test plan
- Reset with w_run=1, w_imem_ready=1, w_ir=0x002082B3 (add x5,x1,x2). Required response:
  - w_ir_en in cycle 1, w_alu_op=0 from cycle 2;
  - w_pc_en and w_rf_we both high in cycle 4;
  - w_retired=1 after the edge; state returns to FETCH.
- Program sequence ADD, 0x406283B3 (sub x7,x5,x6), 0x0020F333 (and x6,x1,x2), 0x0020E333 (or x6,x1,x2), then 0x00000073. Required response:
  - w_alu_op follows 0, 1, 2, 3;
  - w_retired=4; then w_halted=1, w_illegal=0, w_pc_en stays 0 forever.
- w_ir=0x00000013 (addi, unsupported): HALT after DECODE with w_illegal=1, w_retired unchanged, no w_rf_we pulse.
- w_ir=0x00208033 (add x0,x1,x2): WB cycle has w_pc_en=1 and w_rf_we=0; w_retired still increments.
- w_imem_ready low for 3 cycles in FETCH: no w_ir_en until it rises; latency becomes 7 cycles. Dropping w_run during EXEC: WB completes, then IDLE.
- Assert w_rst_n=0 during EXEC, and separately during HALT: next cycle IDLE, all outputs at reset values, no WB pulse. w_run=1 afterwards restarts from FETCH.
